// File: rtl/matrix_a_gen_ctrl.sv
// Row-by-row matrix A generation sequencer: requests one SHAKE hash per row and streams the
// squeezed 448-bit words into a ping-pong RAM448 bank pair shared with the MAC consumer.
module matrix_a_gen_ctrl #(
    parameter int unsigned ROWS_PER_BANK = 4,
    parameter int unsigned IDX_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       sec_lvl,
    output logic             hash_req,
    output logic [IDX_W-1:0] hash_index,
    input  logic             hash_ack,
    output logic             sqz_en,
    input  logic             sqz_val,
    output logic             we_ram448,
    output logic [8:0]       addr_448ramw,
    output logic [1:0]       bank_ready,
    input  logic [1:0]       bank_release,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitBank,
        StReq,
        StSqz,
        StRowEnd,
        StFinish
    } state_e;

    state_e           state;
    logic [IDX_W-1:0] row;
    logic [5:0]       word;
    logic [2:0]       rib;
    logic             bank;
    logic [7:0]       wptr;
    logic [IDX_W-1:0] nrows;
    logic [5:0]       wpr;

    logic [IDX_W-1:0] nrows_dec;
    logic [5:0]       wpr_dec;
    logic             bank_full;
    logic [1:0]       bank_set;

    always_comb begin
        nrows_dec = IDX_W'(640);
        wpr_dec   = 6'd23;
        case (sec_lvl)
            2'd1: begin
                nrows_dec = IDX_W'(976);
                wpr_dec   = 6'd35;
            end
            2'd2: begin
                nrows_dec = IDX_W'(1344);
                wpr_dec   = 6'd48;
            end
            default: ;
        endcase
    end

    // A bank completes on the ROW_END of its last row; it is only ever filled while free,
    // so the set can never collide with a release of the same bank.
    assign bank_full = (rib + 3'd1) == 3'(ROWS_PER_BANK);
    assign bank_set  = (state == StRowEnd && bank_full) ? (2'b01 << bank) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            row        <= '0;
            word       <= '0;
            rib        <= '0;
            bank       <= 1'b0;
            wptr       <= '0;
            nrows      <= '0;
            wpr        <= '0;
            bank_ready <= '0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            bank_ready <= (bank_ready & ~bank_release) | bank_set;
            unique case (state)
                StIdle: begin
                    if (start && sec_lvl != 2'd3) begin
                        nrows <= nrows_dec;
                        wpr   <= wpr_dec;
                        row   <= '0;
                        rib   <= '0;
                        bank  <= 1'b0;
                        wptr  <= '0;
                        state <= StWaitBank;
                    end
                end
                StWaitBank: begin
                    if (!bank_ready[bank]) state <= StReq;
                end
                StReq: begin
                    if (hash_ack) begin
                        word  <= '0;
                        state <= StSqz;
                    end
                end
                StSqz: begin
                    if (sqz_val) begin
                        word <= word + 6'd1;
                        wptr <= wptr + 8'd1;
                        if (word == wpr - 6'd1) state <= StRowEnd;
                    end
                end
                StRowEnd: begin
                    row <= row + IDX_W'(1);
                    rib <= rib + 3'd1;
                    if (bank_full) begin
                        bank <= ~bank;
                        wptr <= '0;
                        rib  <= '0;
                    end
                    if (row + IDX_W'(1) == nrows) begin
                        state <= StFinish;
                    end else if (bank_full) begin
                        state <= StWaitBank;
                    end else begin
                        state <= StReq;
                    end
                end
                StFinish: begin
                    if (bank_ready == 2'b00) begin
                        done  <= 1'b1;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign hash_req     = (state == StReq);
    assign hash_index   = row;
    assign sqz_en       = (state == StSqz);
    assign we_ram448    = (state == StSqz) && sqz_val;
    assign addr_448ramw = {bank, wptr};
    assign busy         = (state != StIdle);

endmodule

// File: tb/tb_matrix_a_gen_ctrl.sv
// Bench for matrix_a_gen_ctrl: randomized SHAKE/consumer agents, with every RAM write checked
// against an arithmetic row/word address model.
module tb_matrix_a_gen_ctrl;

    localparam int unsigned RPB = 4;
    localparam int unsigned IW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    sec_lvl;
    logic          hash_req;
    logic [IW-1:0] hash_index;
    logic          hash_ack;
    logic          sqz_en;
    logic          sqz_val;
    logic          we_ram448;
    logic [8:0]    addr_448ramw;
    logic [1:0]    bank_ready;
    logic [1:0]    bank_release;
    logic          busy;
    logic          done;

    matrix_a_gen_ctrl #(
        .ROWS_PER_BANK(RPB),
        .IDX_W        (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sec_lvl     (sec_lvl),
        .hash_req    (hash_req),
        .hash_index  (hash_index),
        .hash_ack    (hash_ack),
        .sqz_en      (sqz_en),
        .sqz_val     (sqz_val),
        .we_ram448   (we_ram448),
        .addr_448ramw(addr_448ramw),
        .bank_ready  (bank_ready),
        .bank_release(bank_release),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Agent configuration, set by the main sequence.
    int         cur_wpr   = 23;
    int         ack_dly   = 0;
    int         rel_dly   = 5;
    bit         gap_mode  = 1'b0;
    logic [1:0] hold      = 2'b00;
    logic [1:0] force_rel = 2'b00;

    // Reference model state.
    int exp_row  = 0;
    int exp_word = 0;
    int exp_req  = 0;
    int n_wr_run = 0;
    int n_rise   = 0;
    int n_done   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Row r lands in bank (r/RPB)%2 at offset (r%RPB)*wpr + w.
    function automatic logic [31:0] exp_addr(input int r, input int w);
        return 32'(((r / RPB) % 2) * 256 + (r % RPB) * cur_wpr + w);
    endfunction

    // Monitor and reference model, sampled on the falling edge.
    initial begin
        logic [1:0] prev_rdy;
        prev_rdy = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_row  = 0;
                exp_word = 0;
                exp_req  = 0;
                n_wr_run = 0;
                prev_rdy = 2'b00;
            end else begin
                check_eq("we_decode", 32'(we_ram448), 32'(sqz_en & sqz_val));
                if (we_ram448) begin
                    check_eq("wr_addr", 32'(addr_448ramw), exp_addr(exp_row, exp_word));
                    if (exp_row == 4 && exp_word == 0)
                        check_eq("row4_base", 32'(addr_448ramw), 32'h100);
                    n_wr_run++;
                    exp_word++;
                    if (exp_word == cur_wpr) begin
                        exp_word = 0;
                        exp_row++;
                    end
                end
                if (hash_req && hash_ack) begin
                    check_eq("hash_index", 32'(hash_index), 32'(exp_req));
                    check_eq("wr_before_req", 32'(n_wr_run), 32'(exp_req * cur_wpr));
                    exp_req++;
                end
                n_rise += $countones(bank_ready & ~prev_rdy);
                prev_rdy = bank_ready;
                if (done) n_done++;
            end
        end
    end

    // SHAKE and consumer agent.
    initial begin
        int         ack_wait;
        int         rel_cnt [2];
        logic [1:0] a_prev;
        ack_wait     = 0;
        rel_cnt      = '{0, 0};
        a_prev       = 2'b00;
        hash_ack     = 1'b0;
        sqz_val      = 1'b0;
        bank_release = 2'b00;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                hash_ack     = 1'b0;
                sqz_val      = 1'b0;
                bank_release = 2'b00;
                ack_wait     = 0;
                rel_cnt      = '{0, 0};
                a_prev       = 2'b00;
            end else begin
                hash_ack = 1'b0;
                if (hash_req) begin
                    if (ack_wait >= ack_dly) begin
                        hash_ack = 1'b1;
                        ack_wait = 0;
                        if (gap_mode) ack_dly = int'($urandom_range(0, 3));
                    end else begin
                        ack_wait++;
                    end
                end else begin
                    ack_wait = 0;
                end
                if (sqz_en) sqz_val = gap_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                else        sqz_val = gap_mode && ($urandom_range(0, 3) == 0);
                for (int b = 0; b < 2; b++) begin
                    bank_release[b] = 1'b0;
                    if (rel_cnt[b] > 0) begin
                        rel_cnt[b]--;
                        if (rel_cnt[b] == 0) bank_release[b] = 1'b1;
                    end
                    if (bank_ready[b] && !a_prev[b] && !hold[b]) rel_cnt[b] = rel_dly;
                    if (force_rel[b] && bank_ready[b]) begin
                        bank_release[b] = 1'b1;
                        force_rel[b]    = 1'b0;
                    end
                    a_prev[b] = bank_ready[b];
                end
            end
        end
    end

    task automatic pulse_start(input logic [1:0] lvl);
        @(posedge clk);
        #1;
        start   = 1'b1;
        sec_lvl = lvl;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        force_rel = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req"}, 32'(hash_req), 0);
        check_eq({tag, "_idx"}, 32'(hash_index), 0);
        check_eq({tag, "_sqz"}, 32'(sqz_en), 0);
        check_eq({tag, "_we"}, 32'(we_ram448), 0);
        check_eq({tag, "_addr"}, 32'(addr_448ramw), 0);
        check_eq({tag, "_rdy"}, 32'(bank_ready), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        int w;
        int rise0;
        int done0;
        rst     = 1'b1;
        start   = 1'b0;
        sec_lvl = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reserved security level must not start anything.
        pulse_start(2'd3);
        repeat (4) begin
            @(negedge clk);
            check_eq("ill_busy", 32'(busy), 0);
            check_eq("ill_req", 32'(hash_req), 0);
        end

        // Start latency, then reset in the middle of row 2's squeeze.
        cur_wpr = 23;
        ack_dly = 0;
        pulse_start(2'd0);
        check_eq("lat_busy", 32'(busy), 1);
        check_eq("lat_wait_req", 32'(hash_req), 0);
        @(posedge clk);
        #1;
        check_eq("lat_req", 32'(hash_req), 1);
        w = 0;
        while (!(sqz_en && hash_index == 2) && w < 2000) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq("row2_sqz_reached", 32'(w < 2000), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full sec_lvl=0 run with a consumer that releases each bank 5 cycles after ready.
        rise0 = n_rise;
        done0 = n_done;
        pulse_start(2'd0);
        w = 0;
        while (n_done == done0 && w < 40000) begin
            @(negedge clk);
            w++;
        end
        check_eq("full_done_seen", 32'(w < 40000), 1);
        repeat (5) @(negedge clk);
        check_eq("full_writes", 32'(n_wr_run), 32'd14720);
        check_eq("full_rows", 32'(exp_row), 32'd640);
        check_eq("full_rises", 32'(n_rise - rise0), 32'd160);
        check_eq("full_done_cnt", 32'(n_done - done0), 32'd1);
        check_eq("full_idle", 32'(busy), 0);
        check_eq("full_rdy", 32'(bank_ready), 0);

        // Back-pressure: bank 0 never released by the consumer.
        do_reset();
        cur_wpr = 48;
        hold    = 2'b01;
        pulse_start(2'd2);
        w = 0;
        while (exp_row < 8 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check_eq("bp_rows_reached", 32'(w < 5000), 1);
        repeat (30) @(negedge clk);
        check_eq("bp_req_low", 32'(hash_req), 0);
        check_eq("bp_busy", 32'(busy), 1);
        check_eq("bp_index", 32'(hash_index), 32'd8);
        check_eq("bp_rdy0", 32'(bank_ready[0]), 1);
        check_eq("bp_writes", 32'(n_wr_run), 32'(8 * 48));
        hold      = 2'b00;
        force_rel = 2'b01;
        w = 0;
        while (!we_ram448 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("bp_resume_seen", 32'(w < 200), 1);
        check_eq("bp_resume_addr", 32'(addr_448ramw), 32'h000);
        check_eq("bp_resume_index", 32'(hash_index), 32'd8);

        // Gapped squeeze with spurious valids, random ack latency, and a start while busy.
        do_reset();
        cur_wpr  = 35;
        ack_dly  = 1;
        gap_mode = 1'b1;
        pulse_start(2'd1);
        w = 0;
        while (exp_row < 5 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check_eq("gap_row5_reached", 32'(w < 5000), 1);
        pulse_start(2'd0);
        w = 0;
        while (exp_row < 12 && w < 8000) begin
            @(negedge clk);
            w++;
        end
        check_eq("gap_row12_reached", 32'(w < 8000), 1);
        check_eq("gap_busy", 32'(busy), 1);
        check_eq("gap_writes", 32'(n_wr_run), 32'(12 * 35));
        repeat (3) @(negedge clk);
        check_eq("gap_index_cont", 32'(hash_index >= 12), 1);
        gap_mode = 1'b0;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_a_gen_ctrl.md
# matrix_a_gen_ctrl

Sequencer that generates the public matrix A row by row through the SHAKE core and streams the 448-bit squeeze words into RAM448 as a ping-pong double buffer. The MAC datapath consumes one bank while the controller fills the other. The block sits between the top-level `control` FSM (start/done), the SHAKE index/squeeze handshake, and the RAM448 write port.

## Interface
- `ROWS_PER_BANK`, default 4: matrix rows per RAM448 bank.
- `IDX_W`, default 16: width of the row index sent to SHAKE.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins generation of all n rows.
- `sec_lvl`  in  2  selects n and words/row:
  - 0: n=640, 23 words/row.
  - 1: n=976, 35 words/row.
  - 2: n=1344, 48 words/row.
  - 3: reserved.
- `hash_req`  out  1  row hash request, held until acknowledged.
- `hash_index`  out  IDX_W  current row index i.
- `hash_ack`  in  1  SHAKE accepted the request (one cycle).
- `sqz_en`  out  1  squeeze enable.
- `sqz_val`  in  1  SHAKE 448-bit word valid.
- `we_ram448`  out  1  RAM448 write enable.
- `addr_448ramw`  out  9  RAM448 write address: {bank, wptr[7:0]}.
- `bank_ready`  out  2  bank b holds ROWS_PER_BANK complete rows.
- `bank_release`  in  2  consumer frees bank b (one-cycle pulse per bit).
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse when all rows have been generated and consumed.

## Operation
- **States:** IDLE, WAIT_BANK, REQ, SQZ, ROW_END, FINISH.
- **Registers:**
  - `row`: IDX_W bits.
  - `word`: 6 bits.
  - `rib` (rows in bank): 3 bits.
  - `bank`: 1 bit.
  - `wptr`: 8 bits.
  - `nrows`, `wpr`: sec_lvl decode, latched at start.
- **IDLE:**
  - `start` with sec_lvl≠3: latch nrows/wpr, clear row, rib, bank, wptr, go to WAIT_BANK.
  - `start` with sec_lvl=3: ignored, stay in IDLE.
- **WAIT_BANK:** go to REQ when `bank_ready[bank]`=0.
- **REQ:**
  - `hash_req`=1, `hash_index`=row.
  - On `hash_ack`: clear word, go to SQZ.
- **SQZ:**
  - `sqz_en`=1.
  - Each `sqz_val`: `we_ram448`=1, `addr_448ramw`={bank,wptr} in the same cycle (combinational), then word++ and wptr++.
  - On the `sqz_val` where word=wpr−1: go to ROW_END.
- **ROW_END:** row++, rib++.
  - If rib+1=ROWS_PER_BANK: set `bank_ready[bank]`, toggle bank, clear wptr and rib.
  - Then if row+1=nrows go to FINISH.
  - Else if a bank was completed this cycle go to WAIT_BANK.
  - Else go to REQ.
- **FINISH:** when `bank_ready`=0, pulse `done` and go to IDLE.
- **`bank_release[b]`:** clears `bank_ready[b]` in any state. A release of a bank that is not ready has no effect. Set and release of the same bank in one cycle cannot occur, because a bank is filled only while it is free.
- **Ignored inputs:**
  - `start` while busy is ignored.
  - `sqz_val` outside SQZ is ignored: no write, no count.
  - `hash_ack` outside REQ is ignored.
- **Capacity:** per-bank capacity is 4×48=192 words, less than 256. wptr never wraps into the other bank.

## Timing
- **Reset values:** all outputs 0; state IDLE; all registers 0. `rst` mid-operation aborts immediately, with no `done` and no further writes.
- **Start latency:** `start` at cycle t, state WAIT_BANK at t+1, REQ with `hash_req`=1 at t+2 (banks free).
- **Request handshake:** `hash_req` stays high until the cycle `hash_ack` is sampled. `sqz_en` is high from the next cycle.
- **Squeeze handshake:** `sqz_en` drops the cycle after the last word is written. SHAKE must not present `sqz_val` while `sqz_en`=0.
- **Row overhead:** 2 cycles plus SHAKE ack latency (ROW_END, then REQ).
- **Bank ready:** `bank_ready[b]` rises the cycle after ROW_END of the 4th row.
- **Done:** `done` asserts the cycle after the final release is observed as `bank_ready`=0, or 1 cycle after entering FINISH if already 0.

## Test plan
- **Reset mid-SQZ:** sec_lvl=0, start, reset asserted in SQZ on row 2 → all outputs 0 next cycle; a subsequent start works normally.
- **Full run, sec_lvl=0:** SHAKE acks in 1 cycle, `sqz_val` every cycle, consumer releases each bank 5 cycles after ready → 14720 writes total. Row 0 addresses 0x000–0x016; row 4 starts at 0x100; 160 `bank_ready` rises; exactly one `done`.
- **Back-pressure, sec_lvl=2:** consumer never releases bank 0 → after 8 rows, FSM idles in WAIT_BANK with `hash_req`=0. Releasing bank 0 resumes with `hash_index`=8 at address 0x000.
- **Gapped squeeze, sec_lvl=1:** `sqz_val` randomly gapped, spurious `sqz_val` injected in REQ and ROW_END → exactly 35 writes per row, contiguous addresses, none in other states.
- **Illegal start:** sec_lvl=3 start → busy stays 0, no `hash_req`.
- **Start while busy:** start pulsed while busy → no restart; row counter continues.
